// File: rtl/pcie_axi_to_sram_if.sv
// AXI read channel plus SRAM read port for the pcie_axi_to_sram bridge.
// The slave modport is the bridge; master is the AXI requester together with the SRAM.
interface pcie_axi_to_sram_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10
);
  logic                  axi_arvalid;
  logic [63:0]           axi_araddr;
  logic [11:0]           axi_arlen;
  logic [2:0]            axi_arsize;
  logic [1:0]            axi_arburst;
  logic                  axi_arready;
  logic                  axi_rvalid;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rready;
  logic                  sram_ren;
  logic [ADDR_WIDTH-1:0] sram_raddr;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready, sram_rdata,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, sram_ren, sram_raddr
  );

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready, sram_rdata,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, sram_ren, sram_raddr
  );
endinterface

// File: rtl/pcie_axi_to_sram.sv
// AXI read-burst to single-port SRAM bridge: one SRAM word fetched per beat,
// one outstanding burst at a time.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | ready for a new AR request (arready = 1)
// S_FETCH | SRAM read issued for the current word index
// S_WAIT  | SRAM data returning, captured into the rdata register
// S_DATA  | beat presented on R channel, held until rready
module pcie_axi_to_sram #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pcie_axi_to_sram_if.slave       bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [12:0]           r_cnt;
  logic [1:0]            r_burst;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_unused;

  assign w_ar_hs = bus.axi_arvalid && (r_state == S_IDLE);
  assign w_r_hs  = bus.axi_rready  && (r_state == S_DATA);

  // Size and the byte offset within a word do not affect the transfer.
  assign w_unused = ^{bus.axi_arsize, bus.axi_araddr[63:ADDR_WIDTH+5], bus.axi_araddr[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_idx   <= bus.axi_araddr[ADDR_WIDTH+4:5];
            r_cnt   <= {1'b0, bus.axi_arlen} + 13'd1;
            r_burst <= bus.axi_arburst;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_rdata <= bus.sram_rdata;
          r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_r_hs) begin
            r_cnt <= r_cnt - 13'd1;
            // FIXED holds the index; INCR, WRAP and reserved all step and wrap naturally.
            if (r_burst != 2'b00) r_idx <= r_idx + ADDR_WIDTH'(1);
            r_state <= (r_cnt == 13'd1) ? S_IDLE : S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.axi_arready = (r_state == S_IDLE);
  assign bus.axi_rvalid  = (r_state == S_DATA);
  assign bus.axi_rdata   = r_rdata;
  assign bus.axi_rresp   = 2'b00;
  assign bus.axi_rlast   = (r_state == S_DATA) && (r_cnt == 13'd1);
  assign bus.sram_ren    = (r_state == S_FETCH);
  assign bus.sram_raddr  = r_idx;
endmodule

// File: tb/tb_pcie_axi_to_sram.sv
// Self-checking bench for pcie_axi_to_sram: directed vector table, reset and
// long-burst sequences, then randomized bursts against a word-index model.
module tb_pcie_axi_to_sram;
  localparam int DW = 256;
  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_axi_to_sram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  pcie_axi_to_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [NW];
  int checks = 0;
  int failures = 0;

  // Synchronous SRAM: data appears the cycle after ren is sampled.
  always @(posedge clk) if (bus.sram_ren) bus.sram_rdata <= mem[bus.sram_raddr];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word index of beat k: byte address / 32 modulo memory depth, stepping unless FIXED.
  function automatic int exp_idx(input logic [63:0] addr, input int k, input logic [1:0] burst);
    int base;
    base = int'((addr / 64'd32) % 64'(NW));
    return (burst == 2'b00) ? base : (base + k) % NW;
  endfunction

  task automatic run_burst(input string tag, input logic [63:0] addr, input int len,
                           input logic [1:0] burst, input int stall_beat, input int stall_cyc,
                           input bit rand_stall, output int first_idx, output int last_idx);
    int beat, lat, stalled, budget, ren_n;
    bit seen, stall;
    bus.axi_arvalid = 1'b1;
    bus.axi_araddr  = addr;
    bus.axi_arlen   = 12'(len);
    bus.axi_arburst = burst;
    bus.axi_arsize  = 3'($urandom);
    bus.axi_rready  = 1'b0;
    chk({tag, " arready_idle"}, bus.axi_arready, 1);
    @(negedge clk);
    beat = 0; lat = 1; stalled = 0; seen = 0; ren_n = 0;
    first_idx = -1; last_idx = -1;
    budget = (len + 1) * (stall_cyc + 30) + 20;
    while (beat <= len) begin
      if (budget == 0) begin
        checks++; failures++;
        $display("FAIL %s timeout actual_beats=%0d required_beats=%0d", tag, beat, len + 1);
        break;
      end
      budget--;
      // Competing AR requests during the burst must be ignored.
      bus.axi_arvalid = 1'($urandom_range(0, 1));
      bus.axi_araddr  = {$urandom, $urandom};
      chk({tag, " arready_busy"}, bus.axi_arready, 0);
      if (bus.sram_ren) begin
        if (ren_n == 0) first_idx = int'(bus.sram_raddr);
        last_idx = int'(bus.sram_raddr);
        chk({tag, " sram_raddr"}, bus.sram_raddr, exp_idx(addr, ren_n, burst));
        ren_n++;
      end
      if (bus.axi_rvalid) begin
        if (!seen) begin
          chk({tag, " latency"}, lat, 3);
          seen = 1;
        end
        chk({tag, " rdata"}, bus.axi_rdata, mem[exp_idx(addr, beat, burst)]);
        chk({tag, " rlast"}, bus.axi_rlast, (beat == len));
        chk({tag, " rresp"}, bus.axi_rresp, 0);
        stall = 0;
        if (beat == stall_beat && stalled < stall_cyc) begin
          stall = 1; stalled++;
        end else if (rand_stall && $urandom_range(0, 2) == 0) begin
          stall = 1;
        end
        if (stall) bus.axi_rready = 1'b0;
        else begin
          bus.axi_rready = 1'b1;
          beat++; lat = 0; seen = 0;
        end
      end else begin
        bus.axi_rready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    bus.axi_arvalid = 1'b0;
    bus.axi_rready  = 1'b0;
    chk({tag, " ren_count"}, ren_n, len + 1);
    chk({tag, " arready_after"}, bus.axi_arready, 1);
    chk({tag, " rvalid_after"}, bus.axi_rvalid, 0);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          len;
    logic [1:0]  burst;
    int          stall_beat;
    int          stall_cyc;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fi, li, nbeat, quiet;
    bus.axi_arvalid = 1'b0;
    bus.axi_araddr  = '0;
    bus.axi_arlen   = '0;
    bus.axi_arsize  = '0;
    bus.axi_arburst = '0;
    bus.axi_rready  = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
    mem[0] = {32{8'hA5}};

    vecs[0] = '{64'h0,                   0, 2'b01, -1, 0,    0,    0};
    vecs[1] = '{64'h40,                  3, 2'b01, -1, 0,    2,    5};
    vecs[2] = '{64'h0,                   1, 2'b01,  0, 5,    0,    1};
    vecs[3] = '{64'h20,                  2, 2'b00, -1, 0,    1,    1};
    vecs[4] = '{64'h7FE0,                1, 2'b01, -1, 0, 1023,    0};
    vecs[5] = '{64'h7FE0,                2, 2'b10,  1, 3, 1023,    1};
    vecs[6] = '{64'h1234_5678_0000_0060, 2, 2'b11, -1, 0,    3,    5};

    // Reset state, with the clock running.
    @(negedge clk);
    @(negedge clk);
    chk("rst arready", bus.axi_arready, 1);
    chk("rst rvalid", bus.axi_rvalid, 0);
    chk("rst rlast", bus.axi_rlast, 0);
    chk("rst rresp", bus.axi_rresp, 0);
    chk("rst rdata", bus.axi_rdata, 0);
    chk("rst sram_ren", bus.sram_ren, 0);
    chk("rst sram_raddr", bus.sram_raddr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      run_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].burst,
                vecs[v].stall_beat, vecs[v].stall_cyc, 1'b0, fi, li);
      chk($sformatf("vec%0d first_idx", v), fi, vecs[v].exp_first);
      chk($sformatf("vec%0d last_idx", v), li, vecs[v].exp_last);
      @(negedge clk);
    end

    // Reset asserted while beat 2 of 4 is presented.
    bus.axi_arvalid = 1'b1; bus.axi_araddr = 64'h80; bus.axi_arlen = 12'd3; bus.axi_arburst = 2'b01;
    @(negedge clk);
    bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b1;
    nbeat = 0;
    for (int c = 0; c < 40 && nbeat < 2; c++) begin
      if (bus.axi_rvalid) nbeat++;
      if (nbeat < 2) @(negedge clk);
    end
    chk("mid rvalid_beat2", bus.axi_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid rvalid", bus.axi_rvalid, 0);
    chk("mid arready", bus.axi_arready, 1);
    chk("mid rlast", bus.axi_rlast, 0);
    chk("mid rdata", bus.axi_rdata, 0);
    chk("mid sram_ren", bus.sram_ren, 0);
    chk("mid sram_raddr", bus.sram_raddr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.axi_rvalid || bus.sram_ren) quiet++;
    end
    chk("mid no_beats_after_release", quiet, 0);
    bus.axi_rready = 1'b0;
    run_burst("post_reset", 64'hA0, 1, 2'b01, -1, 0, 1'b0, fi, li);
    chk("post_reset first_idx", fi, 5);

    // Maximum-length INCR burst wraps the whole memory.
    run_burst("max_len", 64'd500 * 64'd32, 4095, 2'b01, -1, 0, 1'b0, fi, li);
    chk("max_len last_idx", li, 499);

    // Randomized bursts over randomized memory contents.
    for (int i = 0; i < NW; i++)
      for (int j = 0; j < DW / 32; j++) mem[i][j*32 +: 32] = $urandom;
    for (int t = 0; t < 25; t++) begin
      run_burst($sformatf("rnd%0d", t), {$urandom, $urandom}, int'($urandom_range(0, 12)),
                2'($urandom_range(0, 3)), -1, 0, 1'b1, fi, li);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
